hilo_div_ctrl: RTL and testbench

//   Sequences a multi-cycle restoring divider (DIV/DIVU) and writes the 64-bit result to the HI/LO register.

---
 rtl/hilo_div_ctrl_pkg.sv | 15 +
 rtl/hilo_div_ctrl_div_step.sv | 29 ++
 rtl/hilo_div_ctrl.sv | 124 ++++++++++++
 tb/tb_hilo_div_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_div_ctrl_pkg.sv
// Shared encodings for the HI/LO divide sequencer: FSM states and the ALU op codes it serves.
package hilo_div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // SPECIAL-class funct codes decoded upstream into start/is_signed
    localparam logic [5:0] OP_DIV  = 6'h1a;
    localparam logic [5:0] OP_DIVU = 6'h1b;

endpackage

// File: rtl/hilo_div_ctrl_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor, keep or restore, and shift the quotient bit in.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // shifted < 2*den, so a WIDTH+1 bit difference has its MSB set exactly when it went negative
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, den};
        if (diff[WIDTH]) begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: one quotient bit per clock, sign fix-up, then a single-cycle
// HI/LO write of {remainder, quotient}.
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic               dz,
    output logic               hilo_we,
    output logic [2*WIDTH-1:0] hilo_data
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, den, orig;
    logic             sign_q, sign_r, dz_q;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic [WIDTH-1:0] q_fix, r_fix;

    // The most-negative value negates to itself, which is exactly its unsigned magnitude
    assign a_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign b_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem),
        .quo_i (quo),
        .den   (den),
        .rem_o (rem_nxt),
        .quo_o (quo_nxt)
    );

    always_comb begin
        q_fix = sign_q ? -quo : quo;
        r_fix = sign_r ? -rem : rem;
        if (dz_q) begin
            q_fix = '1;
            r_fix = orig;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            den       <= '0;
            orig      <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dz_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dz        <= 1'b0;
            hilo_we   <= 1'b0;
            hilo_data <= '0;
        end else begin
            done    <= 1'b0;
            hilo_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && !flush) begin
                        state  <= ST_CALC;
                        busy   <= 1'b1;
                        cnt    <= CNT_LAST;
                        rem    <= '0;
                        quo    <= a_mag;
                        den    <= b_mag;
                        orig   <= dividend;
                        sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r <= is_signed & dividend[WIDTH-1];
                        dz_q   <= (divisor == '0);
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt - CNT_ONE;
                        if (cnt == '0) state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    busy <= 1'b0;
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        state     <= ST_DONE;
                        hilo_data <= {r_fix, q_fix};
                        dz        <= dz_q;
                        done      <= 1'b1;
                        hilo_we   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Scoreboard bench for hilo_div_ctrl: expected HI/LO pushed at accept, popped and compared on hilo_we.
module tb_hilo_div_ctrl;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           is_signed = 1'b0;
    logic           flush = 1'b0;
    logic [W-1:0]   dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           busy, done, dz, hilo_we;
    logic [2*W-1:0] hilo_data;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           sgn;
        logic [2*W-1:0] data;
        logic           dz;
        int             c0;
    } exp_t;

    exp_t           sb[$];
    exp_t           mon_e;
    int             nvec = 0;
    int             nmis = 0;
    int             cyc = 0;
    logic [2*W-1:0] last_data = '0;
    logic           last_dz = 1'b0;
    logic [W-1:0]   spec[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    hilo_div_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .dz        (dz),
        .hilo_we   (hilo_we),
        .hilo_data (hilo_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
        return (s && x[W-1]) ? -x : x;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input int c0);
        exp_t   e;
        logic [W-1:0] q, r;
        longint sa, sd;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
            q  = W'(sa / sd);
            r  = W'(sa % sd);
        end else begin
            q = a / b;
            r = a % b;
        end
        e.a = a; e.b = b; e.sgn = s; e.data = {r, q}; e.dz = (b == '0); e.c0 = c0;
        return e;
    endfunction

    // Output side of the scoreboard
    always @(negedge clk) begin
        if (rst && (hilo_we || done)) begin
            check("we_eq_done", hilo_we, done);
            if (sb.size() == 0) begin
                check("spurious_we", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("hilo_data", hilo_data, mon_e.data);
                check("dz", dz, mon_e.dz);
                check("latency", cyc, mon_e.c0 + W + 1);
                if (!mon_e.dz) begin
                    check("q*d+r", W'(hilo_data[W-1:0] * mon_e.b + hilo_data[2*W-1:W]), mon_e.a);
                    check("rem_bound", (mag(hilo_data[2*W-1:W], mon_e.sgn) < mag(mon_e.b, mon_e.sgn)) ? 1 : 0, 1);
                end
                last_data = mon_e.data;
                last_dz   = mon_e.dz;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        dividend = a; divisor = b; is_signed = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(a, b, s, cyc));
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", dz, 0);
        check("rst_we", hilo_we, 0);
        check("rst_data", hilo_data, 0);
        rst = 1'b1;

        issue(32'd100, 32'd7, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        check("hold_data", hilo_data, {32'd2, 32'd14});
        check("we_pulse", hilo_we, 0);

        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        drain();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        drain();

        issue(32'd5, 32'd0, 1'b0);
        drain();
        issue(32'hFFFF_FFFB, 32'd0, 1'b1);
        drain();
        repeat (2) @(negedge clk);
        check("dz_hold", dz, 1);

        // start pulsed mid-divide must be dropped
        issue(32'd1000, 32'd10, 1'b0);
        repeat (5) @(negedge clk);
        dividend = 32'd77; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // start held through DONE: second divide accepted with no IDLE bubble
        @(negedge clk);
        dividend = 32'd500; divisor = 32'd9; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(model(32'd500, 32'd9, 1'b0, cyc));
        dividend = 32'hFFFF_FF00; divisor = 32'd13; is_signed = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 100);
            if (!done) check("b2b_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        sb.push_back(model(32'hFFFF_FF00, 32'd13, 1'b1, cyc));
        check("b2b_busy", busy, 1);
        start = 1'b0;
        drain();

        // flush in the 10th CALC cycle
        issue(32'd12345, 32'd17, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        void'(sb.pop_back());
        repeat (W + 5) @(negedge clk);
        check("flush_data", hilo_data, last_data);
        check("flush_dz", dz, last_dz);

        // flush beats start in IDLE
        @(negedge clk);
        dividend = 32'd9; divisor = 32'd2; is_signed = 1'b0; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", busy, 0);
        repeat (W + 5) @(negedge clk);

        // async reset mid-CALC
        issue(32'd999, 32'd3, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_dz", dz, 0);
        check("mrst_we", hilo_we, 0);
        check("mrst_data", hilo_data, 0);
        sb.delete();
        last_data = '0;
        last_dz = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) begin
                    issue(spec[i], spec[j], s[0]);
                    drain();
                end
        for (int k = 0; k < 40; k++) begin
            issue($urandom, (k % 4 == 0) ? W'($urandom_range(0, 20)) : W'($urandom), k[0]);
            drain();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
